imt_apb_master: RTL

IMT_APB_MASTER -- requirements
Module: imt_apb_master

---
 rtl/imt_apb_master.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/imt_apb_master.sv
// imt_apb_master: single-outstanding command-to-APB requester with a PREADY
// watchdog, misalignment rejection and a held response channel.
`default_nettype none

module imt_apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        reset_int,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;

  // Widened so the limit compare cannot wrap at 65535.
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          rdata_d  = '0;
          tmo_d    = 1'b0;
          if (cmd_addr[1:0] == 2'b00) begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = SETUP;
          end else begin
            // Misaligned: answer with an error without touching the bus.
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          err_d   = PSLVERR;
          tmo_d   = 1'b0;
          rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : 32'd0;
          state_d = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc >= TMO_LIMIT)) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;

endmodule

`default_nettype wire
